bin2dig_serializer: RTL and testbench

Sequential radix converter that consumes a 32-bit unsigned binary word and emits its digits in the configured radix, most-significant first, over a valid/ready stream. It sits downstream of the combinational 32÷16 divide core. Each conversion cycle it feeds the running value and a constant divisor to that core, then uses the quotient and remainder it returns. Typical use is decimal readout of counters and divider results for display or UART formatting.

---
 rtl/bin2dig_pkg.sv | 34 +++
 rtl/bin2dig_serializer_div.sv | 43 ++++
 rtl/bin2dig_serializer.sv | 120 ++++++++++++
 tb/tb_bin2dig_serializer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2dig_pkg.sv
// Shared types and constants for the binary-to-digit serializer.
//   state_t          : conversion FSM states
//   DIGIT_W          : width of one emitted digit
//   DATA_W / DIV_W   : dividend and divisor widths of the divide step
//   digits_for_radix : digit count of 2^32-1 in a given radix
package bin2dig_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DIV_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    EMIT
  } state_t;

  // Number of digits needed for the largest 32-bit value in the given radix.
  function automatic int unsigned digits_for_radix(input int unsigned radix);
    longint unsigned v;
    int unsigned     n;
    v = 64'h0000_0000_FFFF_FFFF;
    n = 0;
    if (radix < 2) begin
      return 1;
    end
    while (v != 0) begin
      v = v / 64'(radix);
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2dig_serializer_div.sv
// Combinational 32-bit / 16-bit unsigned divider, non-restoring with a final
// remainder correction.
//   dividend    : 32-bit unsigned numerator
//   divisor     : 16-bit unsigned denominator (must be non-zero)
//   quotient_c  : 32-bit quotient (combinational)
//   remainder_c : 16-bit remainder (combinational)
module dig_div_step
  import bin2dig_pkg::*;
(
  input  logic [DATA_W-1:0] dividend,
  input  logic [DIV_W-1:0]  divisor,
  output logic [DATA_W-1:0] quotient_c,
  output logic [DIV_W-1:0]  remainder_c
);

  // Partial remainder lives in [-2d, 2d) after each shift, so two guard bits.
  localparam int unsigned REM_W = DIV_W + 2;

  always_comb begin
    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] dsr;
    quotient_c  = '0;
    remainder_c = '0;
    dsr         = {2'b00, divisor};
    rem         = '0;
    // Subtract while the partial remainder is non-negative, add otherwise;
    // each quotient bit is the sign of the new partial remainder.
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (!rem[REM_W-1]) begin
        rem = {rem[REM_W-2:0], dividend[i]} - dsr;
      end else begin
        rem = {rem[REM_W-2:0], dividend[i]} + dsr;
      end
      quotient_c[i] = ~rem[REM_W-1];
    end
    // A negative final remainder is one divisor short.
    if (rem[REM_W-1]) begin
      rem = rem + dsr;
    end
    remainder_c = rem[DIV_W-1:0];
  end

endmodule

// File: rtl/bin2dig_serializer.sv
// Sequential radix converter: accepts a 32-bit unsigned word and streams its
// digits in RADIX, most-significant first, without leading zeros.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : input word valid
//   in_ready   : block accepts a word (IDLE only)
//   in_data    : 32-bit value to convert
//   out_valid  : digit available
//   out_ready  : sink accepts digit
//   out_digit  : digit value 0..RADIX-1
//   out_last   : marks the least-significant (final) digit
//   busy       : conversion or emission in progress
module bin2dig_serializer
  import bin2dig_pkg::*;
#(
  parameter int unsigned RADIX = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT_W-1:0] out_digit,
  output logic               out_last,
  output logic               busy
);

  localparam int unsigned MAX_DIGITS = digits_for_radix(RADIX);
  localparam int unsigned CNT_W      = $clog2(MAX_DIGITS + 1);
  localparam int unsigned BUF_DEPTH  = 2 ** CNT_W;

  if (RADIX < 2 || RADIX > 16) begin : g_bad_radix
    $error("bin2dig_serializer: RADIX %0d outside legal range 2..16", RADIX);
  end

  state_t             state;
  logic [DATA_W-1:0]  val;
  logic [CNT_W-1:0]   cnt;
  // Depth rounded up to a power of two so cnt indexes it without truncation.
  logic [DIGIT_W-1:0] dig_buf [BUF_DEPTH];

  logic [DATA_W-1:0]  quo_c;
  logic [DIV_W-1:0]   rem_c;
  logic [DIGIT_W-1:0] digit_c;
  logic               unused_rem_hi;

  dig_div_step u_div (
    .dividend    (val),
    .divisor     (DIV_W'(RADIX)),
    .quotient_c  (quo_c),
    .remainder_c (rem_c)
  );

  assign digit_c       = rem_c[DIGIT_W-1:0];
  assign unused_rem_hi = ^rem_c[DIV_W-1:DIGIT_W];

  // Conversion FSM, LIFO digit buffer and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      val       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_digit <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            val      <= in_data;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end

        CONV: begin
          dig_buf[cnt] <= digit_c;
          cnt          <= cnt + CNT_W'(1);
          val          <= quo_c;
          // The digit written now is the most significant one, so it is
          // presented directly rather than read back from the buffer.
          if (quo_c == '0) begin
            out_valid <= 1'b1;
            out_digit <= digit_c;
            out_last  <= (cnt == CNT_W'(0));
            state     <= EMIT;
          end
        end

        EMIT: begin
          if (out_ready) begin
            cnt <= cnt - CNT_W'(1);
            if (out_last) begin
              out_valid <= 1'b0;
              out_digit <= '0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              // Preload the next digit down so the stream has no bubbles.
              out_digit <= dig_buf[cnt - CNT_W'(2)];
              out_last  <= (cnt == CNT_W'(2));
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2dig_serializer.sv
// Self-checking bench for bin2dig_serializer: three instances (radix 10, 16,
// 2) driven with directed and random words, compared against a digit-string
// model built with plain integer division.
module tb_bin2dig_serializer;

  logic              clk;
  logic              rst;
  logic [2:0]        in_valid;
  logic [2:0]        in_ready;
  logic [2:0][31:0]  in_data;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready;
  logic [2:0][3:0]   out_digit;
  logic [2:0]        out_last;
  logic [2:0]        busy;

  int checks   = 0;
  int failures = 0;

  // Observations from the most recent convert() call.
  string obs_seq;
  int    obs_n;
  int    obs_first;
  int    obs_done;
  int    obs_unstable;
  int    obs_ready_viol;
  int    obs_timeout;
  logic  obs_ready_after;

  bin2dig_serializer #(.RADIX(10)) u_dec (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_digit(out_digit[0]), .out_last(out_last[0]), .busy(busy[0])
  );

  bin2dig_serializer #(.RADIX(16)) u_hex (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_digit(out_digit[1]), .out_last(out_last[1]), .busy(busy[1])
  );

  bin2dig_serializer #(.RADIX(2)) u_bin (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_digit(out_digit[2]), .out_last(out_last[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned radix_of(input int k);
    if (k == 1) return 16;
    if (k == 2) return 2;
    return 10;
  endfunction

  // Reference digit string: "d,d,...,d*" with '*' marking the final digit.
  function automatic string ref_seq(input longint unsigned v, input int unsigned radix);
    int unsigned d[$];
    string s;
    string sep;
    do begin
      d.push_front(int'(v % 64'(radix)));
      v = v / 64'(radix);
    end while (v != 0);
    s = "";
    foreach (d[i]) begin
      if (i == 0) sep = ""; else sep = ",";
      s = $sformatf("%s%s%0h", s, sep, d[i]);
    end
    s = $sformatf("%s*", s);
    return s;
  endfunction

  function automatic int ref_len(input longint unsigned v, input int unsigned radix);
    int n = 0;
    do begin
      v = v / 64'(radix);
      n++;
    end while (v != 0);
    return n;
  endfunction

  // Drive one word through instance k and record what comes out; stall_pct
  // is the chance (0..99) that out_ready is held low on a given cycle.
  task automatic convert(input int k, input logic [31:0] data, input int stall_pct);
    int n;
    bit done;
    bit prev_stall;
    bit rdy;
    logic [3:0] pd;
    logic pl;
    string sep;
    string mark;
    obs_seq = ""; obs_n = 0; obs_first = -1; obs_done = -1;
    obs_unstable = 0; obs_ready_viol = 0; obs_timeout = 0; obs_ready_after = 1'b0;
    in_data[k]  = data;
    in_valid[k] = 1'b1;
    @(negedge clk);
    n = 1;
    in_valid[k] = 1'b0;
    done = 0; prev_stall = 0; pd = '0; pl = 1'b0;
    while (!done && n < 400) begin
      if (prev_stall && (out_valid[k] !== 1'b1 || out_digit[k] !== pd || out_last[k] !== pl))
        obs_unstable++;
      if (in_ready[k] !== 1'b0 || busy[k] !== 1'b1) obs_ready_viol++;
      if (out_valid[k] === 1'b1 && obs_first < 0) obs_first = n;
      rdy = ($urandom_range(99) >= stall_pct);
      out_ready[k] = rdy;
      if (out_valid[k] === 1'b1 && rdy) begin
        if (obs_n == 0) sep = ""; else sep = ",";
        if (out_last[k] === 1'b1) mark = "*"; else mark = "";
        obs_seq = $sformatf("%s%s%0h%s", obs_seq, sep, out_digit[k], mark);
        obs_n++;
        if (out_last[k] === 1'b1) done = 1;
      end
      prev_stall = (out_valid[k] === 1'b1) && !rdy;
      pd = out_digit[k];
      pl = out_last[k];
      @(negedge clk);
      n++;
    end
    out_ready[k] = 1'b0;
    if (done) begin
      obs_done = n;
      obs_ready_after = in_ready[k];
    end else begin
      obs_timeout = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || out_digit[k] !== 4'd0 ||
          out_last[k] !== 1'b0 || busy[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state inst=%0d got rdy=%b vld=%b dig=%h last=%b busy=%b want 1 0 0 0 0",
                 k, in_ready[k], out_valid[k], out_digit[k], out_last[k], busy[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    convert(0, 32'd0, 0);
    checks++;
    if (obs_seq != "0*") begin
      failures++; $display("FAIL zero_digits got=%s want=0*", obs_seq);
    end
    checks++;
    if (obs_first !== 2) begin
      failures++; $display("FAIL zero_first_valid got=%0d want=2", obs_first);
    end
    checks++;
    if (obs_done !== 3 || obs_ready_after !== 1'b1) begin
      failures++;
      $display("FAIL zero_occupancy got done=%0d rdy=%b want done=3 rdy=1", obs_done, obs_ready_after);
    end
  endtask

  task automatic test_max();
    convert(0, 32'hFFFF_FFFF, 0);
    checks++;
    if (obs_seq != "4,2,9,4,9,6,7,2,9,5*") begin
      failures++; $display("FAIL max_digits got=%s want=4,2,9,4,9,6,7,2,9,5*", obs_seq);
    end
    checks++;
    if (obs_first !== 11) begin
      failures++; $display("FAIL max_conv_len got first_valid=%0d want=11", obs_first);
    end
    checks++;
    if (obs_ready_viol !== 0 || obs_done !== 21) begin
      failures++;
      $display("FAIL max_busy_window got viol=%0d done=%0d want viol=0 done=21", obs_ready_viol, obs_done);
    end
  endtask

  task automatic test_back_to_back();
    convert(0, 32'd1000, 0);
    checks++;
    if (obs_seq != "1,0,0,0*") begin
      failures++; $display("FAIL b2b_first_word got=%s want=1,0,0,0*", obs_seq);
    end
    checks++;
    if (obs_ready_after !== 1'b1) begin
      failures++; $display("FAIL b2b_ready_return got=%b want=1", obs_ready_after);
    end
    convert(0, 32'd7, 0);
    checks++;
    if (obs_seq != "7*" || obs_first !== 2) begin
      failures++;
      $display("FAIL b2b_second_word got=%s first=%0d want=7* first=2", obs_seq, obs_first);
    end
  endtask

  task automatic test_stalls();
    string exp;
    convert(0, 32'd123456, 50);
    checks++;
    if (obs_seq != "1,2,3,4,5,6*" || obs_timeout !== 0) begin
      failures++;
      $display("FAIL stall_digits got=%s timeout=%0d want=1,2,3,4,5,6*", obs_seq, obs_timeout);
    end
    checks++;
    if (obs_unstable !== 0) begin
      failures++; $display("FAIL stall_stability got=%0d unstable cycles want=0", obs_unstable);
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    int k;
    int stall;
    string exp;
    for (int t = 0; t < 12; t++) begin
      k = $urandom_range(2);
      v = $urandom;
      if ($urandom_range(1) == 1) v = v >> $urandom_range(31);
      stall = $urandom_range(40);
      convert(k, v, stall);
      exp = ref_seq(64'(v), radix_of(k));
      checks++;
      if (obs_seq != exp || obs_timeout !== 0) begin
        failures++;
        $display("FAIL random_digits inst=%0d val=%0d got=%s want=%s", k, v, obs_seq, exp);
      end
      checks++;
      if (obs_first !== ref_len(64'(v), radix_of(k)) + 1 || obs_unstable !== 0) begin
        failures++;
        $display("FAIL random_timing inst=%0d val=%0d got first=%0d unstable=%0d want first=%0d unstable=0",
                 k, v, obs_first, obs_unstable, ref_len(64'(v), radix_of(k)) + 1);
      end
    end
  endtask

  task automatic test_reset_abort();
    int hs;
    int n;
    string got;
    string sep;
    in_data[0]  = 32'd98765;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    hs = 0; n = 0; got = "";
    while (hs < 2 && n < 100) begin
      if (out_valid[0] === 1'b1) begin
        if (hs == 0) sep = ""; else sep = ",";
        got = $sformatf("%s%s%0h", got, sep, out_digit[0]);
        hs++;
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (got != "9,8") begin
      failures++; $display("FAIL abort_prefix got=%s want=9,8", got);
    end
    rst = 1'b1;
    out_ready[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset got vld=%b rdy=%b busy=%b want 0 1 0", out_valid[0], in_ready[0], busy[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    convert(0, 32'd42, 0);
    checks++;
    if (obs_seq != "4,2*") begin
      failures++; $display("FAIL abort_next_word got=%s want=4,2*", obs_seq);
    end
  endtask

  task automatic test_reset_vs_accept();
    int seen;
    rst = 1'b1;
    in_data[0]  = 32'd5;
    in_valid[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid[0] = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("FAIL reset_wins_accept got=%0d active cycles want=0", seen);
    end
  endtask

  task automatic test_radix();
    convert(1, 32'hDEAD_BEEF, 0);
    checks++;
    if (obs_seq != "d,e,a,d,b,e,e,f*") begin
      failures++; $display("FAIL radix16_digits got=%s want=d,e,a,d,b,e,e,f*", obs_seq);
    end
    convert(2, 32'd5, 0);
    checks++;
    if (obs_seq != "1,0,1*" || obs_first !== 4) begin
      failures++; $display("FAIL radix2_digits got=%s first=%0d want=1,0,1* first=4", obs_seq, obs_first);
    end
    convert(2, 32'hFFFF_FFFF, 0);
    checks++;
    if (obs_n !== 32 || obs_seq != ref_seq(64'hFFFF_FFFF, 2)) begin
      failures++; $display("FAIL radix2_max got n=%0d seq=%s want n=32", obs_n, obs_seq);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '0;
    test_reset();
    test_zero();
    test_max();
    test_back_to_back();
    test_stalls();
    test_radix();
    test_reset_abort();
    test_reset_vs_accept();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
